// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data memory answering byte/half/word loads and stores
// Stores commit at acceptance; the response carries the pre-store word after WAIT_STATES extra cycles.
module data_mem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_wr_data,
  input  logic [1:0]      i_data_mask,
  input  logic            i_data_wr_en,
  input  logic            i_data_req,
  output logic [XLEN-1:0] o_data_rd_data,
  output logic            o_data_ack,
  output logic            o_misaligned
);

  localparam int         AW           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit         LP_NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] LP_WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [3:0]      r_wait_cnt;
  logic            r_armed;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_rd_word;
  logic            r_mis;

  logic            w_accept;
  logic            w_mis;
  logic            w_mem_we;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_old_word;
  logic [XLEN-1:0] w_new_word;
  logic            w_unused;

  assign w_idx      = i_data_addr[2 +: AW];
  assign w_old_word = r_mem[w_idx];
  assign w_unused   = ^i_data_addr[XLEN-1:AW+2];

  // r_armed blocks acceptance on the first edge after reset release.
  assign w_accept = i_data_req && r_armed &&
                    ((r_state == S_IDLE) || (LP_NO_WAIT && (r_state == S_RESP)));
  assign w_mem_we = w_accept && i_data_wr_en && !w_mis;

  always_comb begin
    w_mis = 1'b0;
    case (i_data_mask)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = i_data_addr[0];
      2'b10:   w_mis = |i_data_addr[1:0];
      default: w_mis = 1'b1;
    endcase
  end

  always_comb begin
    w_new_word = w_old_word;
    case (i_data_mask)
      2'b00:   w_new_word[{i_data_addr[1:0], 3'b000} +: 8] = i_data_wr_data[7:0];
      2'b01:   w_new_word[{i_data_addr[1], 4'b0000} +: 16] = i_data_wr_data[15:0];
      default: w_new_word = i_data_wr_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_new_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = LP_NO_WAIT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = w_accept ? S_RESP : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt     <= 4'd0;
      r_armed        <= 1'b0;
      r_rd_word      <= '0;
      r_mis          <= 1'b0;
      o_data_rd_data <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_rd_word  <= w_old_word;
        r_mis      <= w_mis;
        r_wait_cnt <= LP_WAIT_LAST;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      // Read data only moves when a response cycle begins, so it holds between acks.
      if (w_next_state == S_RESP) begin
        o_data_rd_data <= w_accept ? w_old_word : r_rd_word;
      end
    end
  end

  assign o_data_ack   = (r_state == S_RESP);
  assign o_misaligned = (r_state == S_RESP) && r_mis;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed checks of data_mem_responder
// Two instances (no wait states and three wait states) are compared every cycle against a transaction model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wd_s    [2];
  logic [31:0] rd_s    [2];
  logic [1:0]  mask_s  [2];
  logic        wr_s    [2];
  logic        req_s   [2];
  logic        ack_s   [2];
  logic        mis_s   [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit          armed      [2];
  int          free_at    [2];
  bit          pend_v     [2];
  int          pend_cyc   [2];
  logic [31:0] pend_data  [2];
  bit          pend_known [2];
  bit          pend_mis   [2];
  logic [31:0] last_rd    [2];
  bit          last_known [2];
  logic [31:0] mm [2][1024];
  bit          mv [2][1024];

  always #5 clk = ~clk;

  data_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_data_addr(addr_s[0]), .i_data_wr_data(wd_s[0]),
    .i_data_mask(mask_s[0]), .i_data_wr_en(wr_s[0]), .i_data_req(req_s[0]),
    .o_data_rd_data(rd_s[0]), .o_data_ack(ack_s[0]), .o_misaligned(mis_s[0])
  );

  data_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_data_addr(addr_s[1]), .i_data_wr_data(wd_s[1]),
    .i_data_mask(mask_s[1]), .i_data_wr_en(wr_s[1]), .i_data_req(req_s[1]),
    .o_data_rd_data(rd_s[1]), .o_data_ack(ack_s[1]), .o_misaligned(mis_s[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Request/response model: one accepted request yields one ack ws cycles later.
  task automatic model_step(input int d);
    logic [31:0] a, old, nw;
    bit          mis;
    int          idx, sh;
    if (!rst_n[d]) begin
      armed[d] = 0; pend_v[d] = 0; free_at[d] = 0;
    end else if (!armed[d]) begin
      armed[d] = 1;
    end else if (req_s[d] && cyc >= free_at[d]) begin
      a   = addr_s[d];
      idx = int'(a[11:2]);
      mis = (mask_s[d] == 2'b11) || (mask_s[d] == 2'b01 && a[0]) ||
            (mask_s[d] == 2'b10 && a[1:0] != 2'b00);
      old = mm[d][idx];
      pend_v[d] = 1; pend_cyc[d] = cyc + ws_of(d);
      pend_data[d] = old; pend_known[d] = mv[d][idx]; pend_mis[d] = mis;
      free_at[d] = (ws_of(d) == 0) ? cyc + 1 : cyc + ws_of(d) + 2;
      if (wr_s[d] && !mis) begin
        case (mask_s[d])
          2'b00: begin
            sh = 8 * int'(a[1:0]);
            nw = (old & ~(32'hFF << sh)) | ((wd_s[d] & 32'hFF) << sh);
          end
          2'b01: begin
            sh = a[1] ? 16 : 0;
            nw = (old & ~(32'hFFFF << sh)) | ((wd_s[d] & 32'hFFFF) << sh);
          end
          default: nw = wd_s[d];
        endcase
        mm[d][idx] = nw;
        if (mask_s[d] == 2'b10) mv[d][idx] = 1;
      end
    end
  endtask

  task automatic compare(input int d);
    string p;
    p = $sformatf("dut%0d cyc%0d", d, cyc);
    if (!rst_n[d]) begin
      pend_v[d] = 0;
      chk({p, " reset ack"}, {31'd0, ack_s[d]}, 32'd0);
      chk({p, " reset mis"}, {31'd0, mis_s[d]}, 32'd0);
      chk({p, " reset rd"}, rd_s[d], 32'd0);
      last_rd[d] = 32'd0; last_known[d] = 1;
    end else if (pend_v[d] && pend_cyc[d] == cyc) begin
      chk({p, " ack"}, {31'd0, ack_s[d]}, 32'd1);
      chk({p, " mis"}, {31'd0, mis_s[d]}, {31'd0, pend_mis[d]});
      if (pend_known[d]) chk({p, " rd"}, rd_s[d], pend_data[d]);
      last_rd[d] = pend_data[d]; last_known[d] = pend_known[d];
      pend_v[d] = 0;
    end else begin
      chk({p, " idle ack"}, {31'd0, ack_s[d]}, 32'd0);
      chk({p, " idle mis"}, {31'd0, mis_s[d]}, 32'd0);
      if (last_known[d]) chk({p, " rd hold"}, rd_s[d], last_rd[d]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
      @(negedge clk);
      #1;
      compare(0);
      compare(1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] m,
                      input logic w, input bit hold, output logic [31:0] rd, output logic mis,
                      output int lat);
    int c0;
    bit got;
    c0 = cyc; got = 0;
    addr_s[d] = a; wd_s[d] = wd; mask_s[d] = m; wr_s[d] = w; req_s[d] = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      #2;
      got = ack_s[d];
    end
    lat = cyc - c0;
    if (!got) begin
      n_checks++;
      $display("FAIL timeout dut%0d: no ack within 40 cycles for addr 0x%08h", d, a);
    end
    rd = rd_s[d]; mis = mis_s[d];
    if (!hold) req_s[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat, nacks;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; addr_s[d] = '0; wd_s[d] = '0; mask_s[d] = '0; wr_s[d] = 1'b0; req_s[d] = 1'b0;
    end
    tick(3);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        xact(d, ($urandom & 32'hFFFF_F000) | (i << 2), $urandom, 2'b10, 1'b1, i < 15, rd, mis, lat);
      tick(2);
    end

    xact(0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b1, 1, rd, mis, lat);
    chk("ws0 store latency", lat, 1);
    xact(0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, mis, lat);
    chk("ws0 load b2b latency", lat, 1);
    chk("ws0 load DEADBEEF", rd, 32'hDEADBEEF);
    chk("ws0 load aligned mis", {31'd0, mis}, 0);
    xact(0, 32'h10, 32'h11223344, 2'b10, 1'b1, 1, rd, mis, lat);
    xact(0, 32'h13, 32'h000000AA, 2'b00, 1'b1, 1, rd, mis, lat);
    xact(0, 32'h10, 32'h0, 2'b10, 1'b0, 1, rd, mis, lat);
    chk("byte store lane3", rd, 32'hAA223344);
    xact(0, 32'h12, 32'h00005566, 2'b01, 1'b1, 1, rd, mis, lat);
    xact(0, 32'h10, 32'h0, 2'b10, 1'b0, 1, rd, mis, lat);
    chk("half store upper", rd, 32'h55663344);
    xact(0, 32'h20, 32'h0BADF00D, 2'b10, 1'b1, 1, rd, mis, lat);
    xact(0, 32'h21, 32'h0000FFFF, 2'b01, 1'b1, 1, rd, mis, lat);
    chk("misaligned half store flag", {31'd0, mis}, 1);
    xact(0, 32'h22, 32'h0, 2'b10, 1'b0, 1, rd, mis, lat);
    chk("misaligned word load flag", {31'd0, mis}, 1);
    chk("misaligned word load data", rd, 32'h0BADF00D);
    xact(0, 32'h20, 32'h0, 2'b11, 1'b0, 1, rd, mis, lat);
    chk("reserved mask flag", {31'd0, mis}, 1);
    xact(0, 32'h20, 32'h0, 2'b10, 1'b0, 1, rd, mis, lat);
    chk("memory at 0x20 unchanged", rd, 32'h0BADF00D);
    xact(0, 32'h1000, 32'h1, 2'b10, 1'b1, 1, rd, mis, lat);
    xact(0, 32'h0, 32'h0, 2'b10, 1'b0, 0, rd, mis, lat);
    chk("address wrap", rd, 32'h1);

    tick(2);
    for (int i = 0; i < 4; i++) begin
      xact(1, 32'h4, 32'h0, 2'b10, 1'b0, i < 3, rd, mis, lat);
      chk($sformatf("ws3 ack spacing %0d", i), lat, (i == 0) ? 4 : 5);
    end

    tick(2);
    addr_s[1] = 32'h40; wd_s[1] = 32'hCAFEF00D; mask_s[1] = 2'b10; wr_s[1] = 1'b1; req_s[1] = 1'b1;
    tick(2);
    rst_n[1] = 1'b0; req_s[1] = 1'b0; nacks = 0;
    for (int i = 0; i < 3; i++) begin tick(1); nacks += int'(ack_s[1]); end
    rst_n[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(1); nacks += int'(ack_s[1]); end
    chk("ws3 no ack after reset in WAIT", nacks, 0);
    xact(1, 32'h40, 32'h0, 2'b10, 1'b0, 0, rd, mis, lat);
    chk("ws3 post-reset latency", lat, 4);
    chk("ws3 store kept across reset", rd, 32'hCAFEF00D);

    rst_n[0] = 1'b0;
    addr_s[0] = 32'h10; mask_s[0] = 2'b10; wr_s[0] = 1'b0; req_s[0] = 1'b1;
    tick(2);
    rst_n[0] = 1'b1;
    xact(0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, mis, lat);
    chk("ws0 no accept on release edge", lat, 2);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        xact(d, $urandom & 32'hFFFF_F03F, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rd, mis, lat);
        if (!req_s[d]) tick($urandom_range(0, 2));
      end
      req_s[d] = 1'b0;
      tick(6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
